// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multicycle CPU control FSM sequencing fetch/decode/exec/mem/wb
// Optional memory-wait timeout enabled by defining CTRL_TIMEOUT_EN.
module cpu_control_fsm #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [3:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic [1:0]  pc_src,
   output logic        reg_src,
   output logic        alu_src_b,
   output logic [2:0]  alu_op,
   output logic [2:0]  state,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] retired
`ifdef CTRL_TIMEOUT_EN
   ,
   output logic        timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_BEQ   = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hf;

   state_t      state_r;
   state_t      state_n;
   logic        illegal_r;
   logic        illegal_set;
   logic [15:0] retired_r;
   logic        retire;
   logic        is_alu_op;
   logic        waiting;

   assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
   assign waiting   = (state_r == S_FETCH) || (state_r == S_MEM);

`ifdef CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;
   logic          timeout_r;
   logic          wait_expired;

   // Leaving FETCH/MEM requires mem_ready=1, which clears the count, so it
   // always starts from zero on entry.
   assign wait_expired = waiting && !mem_ready && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (waiting && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (wait_expired) begin
            timeout_r <= 1'b1;
         end
      end
   end

   assign timeout = timeout_r;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && waiting;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         illegal_r <= 1'b0;
         retired_r <= 16'd0;
      end else begin
         state_r <= state_n;
         if (illegal_set) begin
            illegal_r <= 1'b1;
         end
         if (retire) begin
            retired_r <= retired_r + 16'd1;
         end
      end
   end

   always_comb begin
      state_n     = state_r;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      pc_src      = 2'd0;
      reg_src     = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = 3'd0;
      illegal_set = 1'b0;
      retire      = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (run) begin
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               state_n = S_HALT;
            end else if (opcode > OP_JMP) begin
               illegal_set = 1'b1;
               state_n     = S_HALT;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  alu_op  = opcode[2:0] - 3'd1;
                  state_n = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 1'b1;
                  state_n   = S_MEM;
               end
               OP_BEQ: begin
                  alu_op = 3'd1;
                  if (alu_zero) begin
                     pc_we  = 1'b1;
                     pc_src = 2'd1;
                  end
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end
               OP_JMP: begin
                  pc_we   = 1'b1;
                  pc_src  = 2'd2;
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end
               default: begin
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            if (opcode == OP_STORE) begin
               mem_we = 1'b1;
            end else begin
               mem_re = 1'b1;
            end
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            reg_src = (opcode == OP_LOAD);
            // Keep the ALU result stable while the register file captures it.
            if (is_alu_op) begin
               alu_op = opcode[2:0] - 3'd1;
            end
            retire  = 1'b1;
            state_n = S_FETCH;
         end
         S_HALT: begin
            state_n = S_HALT;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

`ifdef CTRL_TIMEOUT_EN
      if (wait_expired) begin
         state_n = S_HALT;
      end
`endif
   end

   assign state   = state_r;
   assign halted  = (state_r == S_HALT);
   assign illegal = illegal_r;
   assign retired = retired_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - scoreboard bench for cpu_control_fsm
// Timeout checks are compiled in when CTRL_TIMEOUT_EN is defined.
module tb_cpu_control_fsm;

   localparam int TIMEOUT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [3:0]  opcode;
   logic        alu_zero;
   logic        mem_ready;
   logic        ir_we, pc_we, reg_we, mem_re, mem_we;
   logic [1:0]  pc_src;
   logic        reg_src;
   logic        alu_src_b;
   logic [2:0]  alu_op;
   logic [2:0]  state;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;
`ifdef CTRL_TIMEOUT_EN
   logic        timeout;
`endif

   cpu_control_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
      .mem_re(mem_re), .mem_we(mem_we), .pc_src(pc_src), .reg_src(reg_src),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted),
      .illegal(illegal), .retired(retired)
`ifdef CTRL_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cycles;
      int n_reg;
      int n_mem_re;
      int n_mem_we;
      int n_pc;
      int pc_src;
      int reg_src;
      int wb_alu_op;
      int ex_alu_op;
      int ex_src_b;
      int halted;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_retired = 0;
   int   exp_illegal = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t expect_for(input logic [3:0] op, input int fs, input int ms, input logic z);
      exp_t e;
      bit   alu, ld, st, bad, hlt, taken;
      alu   = (op >= 4'h1) && (op <= 4'h4);
      ld    = (op == 4'h5);
      st    = (op == 4'h6);
      bad   = (op >= 4'h9) && (op <= 4'he);
      hlt   = (op == 4'hf) || bad;
      taken = (op == 4'h8) || ((op == 4'h7) && z);
      if (hlt)                  e.cycles = fs + 2;
      else if (alu)             e.cycles = fs + 4;
      else if (st)              e.cycles = fs + 4 + ms;
      else if (ld)              e.cycles = fs + 5 + ms;
      else                      e.cycles = fs + 3;
      e.n_reg     = (alu || ld) ? 1 : 0;
      e.n_mem_re  = fs + 1 + (ld ? ms + 1 : 0);
      e.n_mem_we  = st ? ms + 1 : 0;
      e.n_pc      = taken ? 2 : 1;
      e.pc_src    = (op == 4'h8) ? 2 : (taken ? 1 : 0);
      e.reg_src   = ld ? 1 : 0;
      e.wb_alu_op = alu ? int'(op) - 1 : 0;
      e.ex_alu_op = alu ? int'(op) - 1 : ((op == 4'h7) ? 1 : 0);
      e.ex_src_b  = (ld || st) ? 1 : 0;
      e.halted    = hlt ? 1 : 0;
      return e;
   endfunction

   // Starts in FETCH at posedge+1; plays memory with fs fetch and ms data wait cycles.
   task automatic run_instr(input logic [3:0] op, input int fs, input int ms, input logic z);
      exp_t e, got;
      int   stall_left, cyc;
      bit   seen_ir, done, ir_now;
      sb.push_back(expect_for(op, fs, ms, z));
      got = '{default: 0};
      stall_left = fs;
      cyc = 0;
      seen_ir = 0;
      done = 0;
      while (!done && cyc < 100) begin
         mem_ready = (stall_left == 0);
         alu_zero  = (cyc == fs + 2) ? z : !z;
         @(negedge clk);
         ir_now = ir_we;
         if (ir_we) seen_ir = 1;
         if (pc_we) begin got.n_pc++; got.pc_src = pc_src; end
         if (reg_we) begin got.n_reg++; got.reg_src = reg_src; got.wb_alu_op = alu_op; end
         if (mem_re) got.n_mem_re++;
         if (mem_we) got.n_mem_we++;
         if (cyc == fs + 2) begin got.ex_alu_op = alu_op; got.ex_src_b = alu_src_b; end
         if (mem_re || mem_we) begin
            if (mem_ready) stall_left = ms;
            else stall_left--;
         end
         cyc++;
         tick();
         if (ir_now) opcode = op;
         if (seen_ir && (state == 3'd1 || state == 3'd6)) done = 1;
      end
      got.cycles = cyc;
      got.halted = halted;
      e = sb.pop_front();
      check($sformatf("op%0h completes", op), done, 1);
      if ((op >= 4'h9) && (op <= 4'he)) exp_illegal = 1;
      if (e.halted == 0) exp_retired++;
      check($sformatf("op%0h cycles", op), got.cycles, e.cycles);
      check($sformatf("op%0h reg_we", op), got.n_reg, e.n_reg);
      check($sformatf("op%0h mem_re", op), got.n_mem_re, e.n_mem_re);
      check($sformatf("op%0h mem_we", op), got.n_mem_we, e.n_mem_we);
      check($sformatf("op%0h pc_we", op), got.n_pc, e.n_pc);
      check($sformatf("op%0h pc_src", op), got.pc_src, e.pc_src);
      check($sformatf("op%0h reg_src", op), got.reg_src, e.reg_src);
      check($sformatf("op%0h wb alu_op", op), got.wb_alu_op, e.wb_alu_op);
      check($sformatf("op%0h ex alu_op", op), got.ex_alu_op, e.ex_alu_op);
      check($sformatf("op%0h ex alu_src_b", op), got.ex_src_b, e.ex_src_b);
      check($sformatf("op%0h halted", op), got.halted, e.halted);
      check($sformatf("op%0h illegal", op), illegal, exp_illegal);
      check($sformatf("op%0h retired", op), retired, exp_retired);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run = 1'b0;
      exp_retired = 0;
      exp_illegal = 0;
      check("reset state", state, 0);
      check("reset retired", retired, 0);
   endtask

   task automatic start_run;
      run = 1'b1;
      tick();
      check("run enters fetch", state, 1);
   endtask

   initial begin
      int bad;
      rst = 1'b1; run = 1'b0; opcode = 4'h0; alu_zero = 1'b0; mem_ready = 1'b0;
      tick();
      run = 1'b1;
      mem_ready = 1'b1;
      tick();
      @(negedge clk);
      check("rst beats run", state, 0);
      check("reset illegal", illegal, 0);
      check("reset halted", halted, 0);
      check("reset strobes", {ir_we, pc_we, reg_we, mem_re, mem_we}, 0);
      check("reset selects", {pc_src, reg_src, alu_src_b, alu_op}, 0);
      check("reset retired", retired, 0);
`ifdef CTRL_TIMEOUT_EN
      check("reset timeout", timeout, 0);
`endif
      tick();
      rst = 1'b0;
      run = 1'b0;
      tick();
      @(negedge clk);
      check("idle without run", state, 0);
      check("idle strobes", {ir_we, pc_we, reg_we, mem_re, mem_we}, 0);
      tick();
      start_run();

      // ADD, LOAD, STORE, HALT with memory always ready
      run_instr(4'h1, 0, 0, 1'b0);
      run_instr(4'h5, 0, 0, 1'b0);
      run_instr(4'h6, 0, 0, 1'b0);
      run_instr(4'hf, 0, 0, 1'b0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!halted || state != 3'd6 || {ir_we, pc_we, reg_we, mem_re, mem_we} != 5'd0) bad++;
         tick();
      end
      check("halt is terminal", bad, 0);

      do_reset();
      start_run();
      run_instr(4'h0, 0, 0, 1'b0);
      run_instr(4'h2, 2, 0, 1'b0);
      run_instr(4'h3, 0, 0, 1'b0);
      run_instr(4'h4, 1, 0, 1'b0);
      run_instr(4'h7, 0, 0, 1'b1);
      run_instr(4'h7, 0, 0, 1'b0);
      run_instr(4'h8, 0, 0, 1'b0);
      run_instr(4'h5, 0, 5, 1'b0);
      run_instr(4'h6, 1, 2, 1'b0);
      run_instr(4'ha, 0, 0, 1'b0);

      // Reset while a STORE is stalled in MEM
      do_reset();
      start_run();
      mem_ready = 1'b1;
      tick();
      opcode = 4'h6;
      tick();
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      check("store mem_we in mem", mem_we, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run = 1'b0;
      exp_retired = 0;
      check("mid-store reset state", state, 0);
      @(negedge clk);
      check("mid-store reset mem_we", mem_we, 0);
      check("mid-store reset strobes", {ir_we, pc_we, reg_we, mem_re, mem_we}, 0);
      check("mid-store reset retired", retired, 0);
      tick();
      start_run();
      run_instr(4'h0, 0, 0, 1'b0);

`ifdef CTRL_TIMEOUT_EN
      do_reset();
      start_run();
      mem_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
         @(negedge clk);
         if (!mem_re || state != 3'd1 || timeout) bad++;
         tick();
      end
      check("waits before timeout", bad, 0);
      check("timeout state", state, 6);
      check("timeout halted", halted, 1);
      check("timeout flag", timeout, 1);
      @(negedge clk);
      check("timeout mem_re dropped", mem_re, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
